// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the nv_ram register-file family.
package nv_ram_pkg;

    // Clear-sequencer states: zero the array after reset, then serve traffic.
    typedef enum logic {
        CLR = 1'b0,
        RDY = 1'b1
    } clr_state_e;

    // Ceiling log2, never below 1 so a 2-row array still gets a 1-bit address.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Even parity bit for one byte lane (makes the 9-bit total even).
    function automatic logic lane_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/nv_ram_clr_seq.sv
// Post-reset clear sequencer: walks every row once writing zero, holding
// init_busy high for exactly DEPTH cycles, then stays ready until reset.
module nv_ram_clr_seq
    import nv_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we,
    output logic          init_busy
);

    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next-state: advance the row counter while clearing, leave CLR after the last row.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == CLR) begin
            if (cnt_q == LAST_ROW) begin
                state_d = RDY;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, counter and registered busy flag; reset restarts the clear from row 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= CLR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_addr  = cnt_q;
    assign clr_we    = (state_q == CLR);
    assign init_busy = busy_q;

endmodule

// File: rtl/nv_ram_rwsp_gen.sv
// Byte-maskable 1R1W register file with a two-stage read (address capture,
// then output-register load), write-to-read bypass and a post-reset clear.
// Optional per-lane even parity is enabled by defining NV_RAM_RWSP_PARITY_EN.
module nv_ram_rwsp_gen
    import nv_ram_pkg::*;
#(
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned LANES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [LANES-1:0] wmask,
    input  logic [WIDTH-1:0] di,
    output logic             init_busy,
    output logic             perr,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [AW-1:0]    clr_addr;
    logic             clr_we;
    logic             busy;

    nv_ram_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk       (clk),
        .rstn      (rstn),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we),
        .init_busy (busy)
    );

    assign init_busy = busy;

    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef NV_RAM_RWSP_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
`endif

    // ra_q is the captured read address; the array itself is never reset.
    logic [AW-1:0]    ra_q, ra_d;
    logic             rd_pend_q, rd_pend_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             wr_ok, rd_ok, byp;
    logic [WIDTH-1:0] rd_row, rd_word;

    assign wr_ok = we && !busy && ({1'b0, wa} < DEPTH_W);
    assign rd_ok = ({1'b0, ra_q} < DEPTH_W);
    assign byp   = wr_ok && (wa == ra_q);
    assign rd_row = rd_ok ? mem[ra_q] : '0;

    // Array write port: clear sequence has priority, user writes are byte-masked.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
`ifdef NV_RAM_RWSP_PARITY_EN
            par_mem[clr_addr] <= '0;
`endif
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem[wa][i*8 +: 8] <= di[i*8 +: 8];
`ifdef NV_RAM_RWSP_PARITY_EN
                    par_mem[wa][i] <= lane_par(di[i*8 +: 8]);
`endif
                end
            end
        end
    end

    // Read word with same-edge write bypass on the written lanes.
    always_comb begin
        rd_word = rd_row;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (byp && wmask[i]) begin
                rd_word[i*8 +: 8] = di[i*8 +: 8];
            end
        end
    end

`ifdef NV_RAM_RWSP_PARITY_EN
    logic             perr_q, perr_d, par_bad;
    logic [LANES-1:0] rd_par;

    // Parity check: bypassed lanes carry freshly computed parity.
    always_comb begin
        rd_par  = rd_ok ? par_mem[ra_q] : '0;
        par_bad = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (byp && wmask[i]) begin
                rd_par[i] = lane_par(di[i*8 +: 8]);
            end
            if (rd_par[i] != lane_par(rd_word[i*8 +: 8])) begin
                par_bad = 1'b1;
            end
        end
        perr_d = perr_q;
        if (!busy && ore) begin
            perr_d = par_bad;
        end
    end

    // Registered parity error, loaded alongside dout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    // Read pipeline control: all user requests are ignored while clearing.
    always_comb begin
        ra_d       = ra_q;
        rd_pend_d  = rd_pend_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        if (!busy) begin
            if (re) begin
                ra_d      = ra;
                rd_pend_d = 1'b1;
            end else if (ore) begin
                rd_pend_d = 1'b0;
            end
            if (ore) begin
                dout_d     = rd_word;
                dout_vld_d = rd_pend_q;
            end
        end
    end

    // Read pipeline registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_q       <= '0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            ra_q       <= ra_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: doc/nv_ram_rwsp_gen.md
NV_RAM_RWSP_GEN -- requirements
Module: nv_ram_rwsp_gen

Interface
REQ-001 SHALL have parameter WIDTH, 128, data width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, 4, row count; minimum 2; need not be a power of two.
REQ-003 SHALL derive localparams AW = clog2(DEPTH) and LANES = WIDTH/8.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ra  in  AW  read address; re  in  1  read-address capture enable.
REQ-007 SHALL have port ore  in  1  output-register load enable.
REQ-008 SHALL have ports dout  out  WIDTH  registered read data; dout_vld  out  1  dout holds a valid read.
REQ-009 SHALL have ports wa  in  AW  write address; we  in  1  write enable; wmask  in  LANES  per-byte write enable; di  in  WIDTH  write data.
REQ-010 SHALL have port init_busy  out  1  clear sequence in progress.
REQ-011 SHALL have port perr  out  1  parity error on the word in dout.
REQ-012 SHALL have port pwrbus_ram_pd  in  32  power-down bus; functionally ignored.

Function
REQ-013 SHALL write byte lane i of di to row wa on a rising edge with we=1, wmask[i]=1 and init_busy=0.
REQ-014 SHALL capture ra into ra_d on an edge with re=1 and init_busy=0; ra_d holds otherwise.
REQ-015 SHALL load dout with row ra_d on an edge with ore=1 and init_busy=0; total latency re->ore->dout is 2 edges minimum; dout holds while ore=0.
REQ-016 SHALL set an internal rd_pend flag on each re capture and load dout_vld from rd_pend on each ore edge.
REQ-017 SHALL bypass on collision: when we=1, wa==ra_d and ore=1 on the same edge, dout takes di for lanes with wmask=1 and the old row for the others.
REQ-018 SHALL ignore writes with wa>=DEPTH; reads with ra_d>=DEPTH SHALL load dout with 0.
REQ-019 SHALL run the clear FSM with states CLR and RDY; reset enters CLR with row counter 0.
REQ-020 SHALL, in CLR, write all-zero to row counter and increment the counter each cycle; after row DEPTH-1 it SHALL enter RDY, giving exactly DEPTH cycles of init_busy=1 after rstn deasserts.
REQ-021 SHALL ignore we, re and ore while init_busy=1; dout, dout_vld and ra_d hold.
REQ-022 SHALL drive init_busy=1 in CLR and 0 in RDY; RDY persists until the next reset.

Reset
REQ-023 SHALL reset asynchronously: dout=0, dout_vld=0, perr=0, ra_d=0, rd_pend=0, init_busy=1, FSM=CLR, counter=0.
REQ-024 SHALL restart the full clear sequence from row 0 when rstn asserts mid-clear.
REQ-025 SHALL NOT reset the storage array directly; zeroing happens only through the clear sequence, so block-RAM inference is preserved.

Configuration
REQ-026 SHALL, with NV_RAM_RWSP_PARITY_EN defined, store one even-parity bit per byte lane, write it with its lane, and clear it to 0 in CLR.
REQ-027 SHALL, with the macro defined, load perr with 1 on an ore edge when any lane's stored parity mismatches its data; bypassed lanes SHALL use freshly computed parity.
REQ-028 SHALL, without the macro, store no parity bits and tie perr to 0; the port list stays unchanged.

Structure
REQ-029 SHALL place the clog2 function, the FSM state typedef (CLR, RDY) and the lane-parity function in shared package nv_ram_pkg.
REQ-030 SHALL implement the clear FSM and row counter as sub-module nv_ram_clr_seq, which outputs clear address, clear write strobe and init_busy.

Verification
REQ-031 SHALL cover: reset release, DEPTH=4 -> init_busy=1 for exactly 4 cycles, then reads of rows 0-3 return 0 with dout_vld=1.
REQ-032 SHALL cover: write row 2 = 0xA5 repeated, wmask all-ones; then read row 2 (re, then ore) -> dout=0xA5 pattern 2 edges after re.
REQ-033 SHALL cover: ra_d=1, row 1=0; we with wa=1, di=all-ones, wmask=0x0001 and ore on the same edge -> dout=0x00..00FF.
REQ-034 SHALL cover: DEPTH=5, write wa=6 -> no row changes; read ra=7 -> dout=0.
REQ-035 SHALL cover: rstn asserted at clear cycle 2 of 4, then released -> 4 further busy cycles and all rows read 0.
REQ-036 SHALL cover, with NV_RAM_RWSP_PARITY_EN: force lane 0 parity bit of row 3 inverted, read row 3 -> perr=1; next clean read -> perr=0.
